// File: rtl/lsu_dtcm_ctrl.sv
// Load/store controller for a 32-bit word data TCM with sub-word read-modify-write stores.
// Optional misaligned/reserved-size trapping is enabled with `define LSU_MISALIGN_TRAP_EN.
module lsu_dtcm_ctrl #(
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [1:0]    i_req_size,
  input  logic          i_req_unsigned,
  input  logic [31:0]   i_req_addr,
  input  logic [31:0]   i_req_wdata,
  output logic          o_rsp_valid,
  output logic [31:0]   o_rsp_rdata,
  output logic          o_rsp_err,
  output logic [AW-1:0] o_mem_raddr,
  output logic          o_mem_ren,
  input  logic [31:0]   i_mem_rdata,
  output logic [AW-1:0] o_mem_waddr,
  output logic [31:0]   o_mem_wdata,
  output logic          o_mem_wen
);

  typedef enum logic [1:0] {S_IDLE, S_LD_RSP, S_RMW_WR, S_RSP} state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_off;
  logic [1:0]    r_size;
  logic          r_uns;
  logic [15:0]   r_wdata;
  logic          r_rsp_valid;
  logic          r_rsp_err;

  logic          w_acc, w_err, w_is_word;
  logic          w_ld_go, w_wst_go, w_rmw_go;
  logic [AW-1:0] w_word_addr;
  logic [31:0]   w_merge, w_lane, w_ext;
  logic          w_unused_addr;

  assign w_word_addr   = i_req_addr[AW+1:2];
  assign w_unused_addr = ^i_req_addr[31:AW+2];
  assign w_is_word     = i_req_size[1];

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_err = (i_req_size == 2'b11) ||
                 (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00) ||
                 (i_req_size == 2'b01 && i_req_addr[0]);
`else
  assign w_err = 1'b0;
`endif

  assign o_req_ready = i_rstn && (r_state == S_IDLE);
  assign w_acc       = i_req_valid && o_req_ready;
  assign w_ld_go     = w_acc && !w_err && !i_req_we;
  assign w_wst_go    = w_acc && !w_err && i_req_we && w_is_word;
  assign w_rmw_go    = w_acc && !w_err && i_req_we && !w_is_word;

  // Reads and word writes go out in the accept cycle; the RMW write follows one cycle later.
  assign o_mem_ren   = w_ld_go || w_rmw_go;
  assign o_mem_raddr = w_word_addr;
  assign o_mem_wen   = i_rstn && ((r_state == S_RMW_WR) || w_wst_go);
  assign o_mem_waddr = (r_state == S_RMW_WR) ? r_addr  : w_word_addr;
  assign o_mem_wdata = (r_state == S_RMW_WR) ? w_merge : i_req_wdata;

  always_comb begin
    w_merge = i_mem_rdata;
    if (r_size == 2'b00) w_merge[{r_off, 3'b000} +: 8]   = r_wdata[7:0];
    else                 w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata;
  end

  always_comb begin
    w_lane = 32'd0;
    w_ext  = i_mem_rdata;
    case (r_size)
      2'b00: begin
        w_lane = i_mem_rdata >> {r_off, 3'b000};
        w_ext  = {{24{!r_uns && w_lane[7]}}, w_lane[7:0]};
      end
      2'b01: begin
        w_lane = i_mem_rdata >> {r_off[1], 4'b0000};
        w_ext  = {{16{!r_uns && w_lane[15]}}, w_lane[15:0]};
      end
      default: w_ext = i_mem_rdata;
    endcase
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = (r_state == S_LD_RSP) ? w_ext : 32'd0;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_off       <= 2'b00;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_wdata     <= 16'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          if (w_acc) begin
            r_addr  <= w_word_addr;
            r_off   <= i_req_addr[1:0];
            r_size  <= i_req_size;
            r_uns   <= i_req_unsigned;
            r_wdata <= i_req_wdata[15:0];
            if (w_err) begin
              r_state     <= S_RSP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (!i_req_we) begin
              r_state     <= S_LD_RSP;
              r_rsp_valid <= 1'b1;
            end else if (w_is_word) begin
              r_state     <= S_RSP;
              r_rsp_valid <= 1'b1;
            end else begin
              r_state     <= S_RMW_WR;
            end
          end
        end
        S_RMW_WR: begin
          r_state     <= S_RSP;
          r_rsp_valid <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dtcm_ctrl.sv
// Self-checking bench for lsu_dtcm_ctrl: directed spec vectors plus randomized traffic
// against a word-array reference model of the TCM.
module tb_lsu_dtcm_ctrl;
  localparam int AW = 4;

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_we = 1'b0;
  logic [1:0]    i_req_size = 2'b00;
  logic          i_req_unsigned = 1'b0;
  logic [31:0]   i_req_addr = 32'd0;
  logic [31:0]   i_req_wdata = 32'd0;
  logic          o_rsp_valid;
  logic [31:0]   o_rsp_rdata;
  logic          o_rsp_err;
  logic [AW-1:0] o_mem_raddr;
  logic          o_mem_ren;
  logic [31:0]   i_mem_rdata = 32'd0;
  logic [AW-1:0] o_mem_waddr;
  logic [31:0]   o_mem_wdata;
  logic          o_mem_wen;

  lsu_dtcm_ctrl #(.AW(AW)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_raddr(o_mem_raddr), .o_mem_ren(o_mem_ren), .i_mem_rdata(i_mem_rdata),
    .o_mem_waddr(o_mem_waddr), .o_mem_wdata(o_mem_wdata), .o_mem_wen(o_mem_wen)
  );

  always #5 i_clk = ~i_clk;

  // Memory attached to the DUT (1-cycle synchronous read).
  logic [31:0] tmem [16];
  always @(posedge i_clk) begin
    if (o_mem_ren) i_mem_rdata <= tmem[o_mem_raddr];
    if (o_mem_wen) tmem[o_mem_waddr] <= o_mem_wdata;
  end

  // Reference model state.
  logic [31:0] ref_mem [16];

  int n_pass = 0, n_tot = 0, n_both = 0, n_leak = 0;

  logic          a_ready, a_ren, a_wen;
  logic [AW-1:0] a_raddr, a_waddr;
  logic [31:0]   a_wdata;
  logic          m_wen;
  logic [AW-1:0] m_waddr;
  logic [31:0]   m_wdata;

  function automatic void ref_op(input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er, output int lat);
    int idx, sh;
    logic [31:0] w, v, mask;
    idx = int'(addr[5:2]);
    w = ref_mem[idx];
    rd = 32'd0; er = 1'b0; lat = 1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (sz == 2'd3 || (sz == 2'd2 && addr[1:0] != 0) || (sz == 2'd1 && addr[0])) begin
      er = 1'b1;
      return;
    end
`endif
    if (sz == 2'd0) begin
      sh = 8 * int'(addr[1:0]);
      mask = 32'hFF;
    end else if (sz == 2'd1) begin
      sh = addr[1] ? 16 : 0;
      mask = 32'hFFFF;
    end else begin
      sh = 0;
      mask = 32'hFFFF_FFFF;
    end
    if (!we) begin
      v = (w >> sh) & mask;
      if (!uns && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
    end else begin
      ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
      if (mask != 32'hFFFF_FFFF) lat = 2;
    end
  endfunction

  // Issues one request starting just after a rising edge; returns the response and its latency.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat);
    i_req_valid = 1'b1; i_req_we = we; i_req_size = sz; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wd;
    @(negedge i_clk);
    a_ready = o_req_ready; a_ren = o_mem_ren; a_wen = o_mem_wen;
    a_raddr = o_mem_raddr; a_waddr = o_mem_waddr; a_wdata = o_mem_wdata;
    if (o_mem_ren && o_mem_wen) n_both++;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0; i_req_we = 1'($urandom); i_req_size = 2'($urandom);
    i_req_addr = $urandom; i_req_wdata = $urandom;
    lat = 0; rd = 32'd0; er = 1'b0; m_wen = 1'b0; m_waddr = '0; m_wdata = 32'd0;
    for (int c = 1; c <= 4 && lat == 0; c++) begin
      @(negedge i_clk);
      if (o_mem_ren && o_mem_wen) n_both++;
      if (c == 1) begin m_wen = o_mem_wen; m_waddr = o_mem_waddr; m_wdata = o_mem_wdata; end
      if (o_rsp_valid) begin lat = c; rd = o_rsp_rdata; er = o_rsp_err; end
      else if (o_rsp_rdata !== 32'd0) n_leak++;
    end
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h8; i_req_we = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_tot++; if (o_req_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", o_req_ready); else n_pass++;
    n_tot++; if (o_mem_ren !== 1'b0) $display("FAIL rst_ren got %b want 0", o_mem_ren); else n_pass++;
    n_tot++; if (o_mem_wen !== 1'b0) $display("FAIL rst_wen got %b want 0", o_mem_wen); else n_pass++;
    n_tot++; if (o_rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", o_rsp_valid); else n_pass++;
    n_tot++; if (o_rsp_rdata !== 32'd0) $display("FAIL rst_rsp_rdata got %h want 0", o_rsp_rdata); else n_pass++;
    n_tot++; if (o_rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %b want 0", o_rsp_err); else n_pass++;
    i_req_valid = 1'b0;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    n_tot++; if (o_req_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", o_req_ready); else n_pass++;
  endtask

  task automatic test_word_and_loads();
    logic [31:0] rd, erd; logic er, eer; int lat, elat;
    ref_op(1'b1, 2'd2, 1'b0, 32'h8, 32'h8000_00F1, erd, eer, elat);
    issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h8000_00F1, rd, er, lat);
    n_tot++; if (a_wen !== 1'b1 || a_ren !== 1'b0) $display("FAIL sw_accept_en got wen=%b ren=%b want 1/0", a_wen, a_ren); else n_pass++;
    n_tot++; if (a_waddr !== 4'd2 || a_wdata !== 32'h8000_00F1) $display("FAIL sw_waddr got %0d/%h want 2/800000f1", a_waddr, a_wdata); else n_pass++;
    n_tot++; if (lat !== 1) $display("FAIL sw_latency got %0d want 1", lat); else n_pass++;
    ref_op(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, erd, eer, elat);
    issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, er, lat);
    n_tot++; if (rd !== 32'h8000_00F1 || lat !== 1) $display("FAIL lw got %h lat %0d want 800000f1 lat 1", rd, lat); else n_pass++;
    issue(1'b0, 2'd0, 1'b0, 32'h8, 32'h0, rd, er, lat);
    n_tot++; if (rd !== 32'hFFFF_FFF1) $display("FAIL lb got %h want fffffff1", rd); else n_pass++;
    issue(1'b0, 2'd0, 1'b1, 32'h8, 32'h0, rd, er, lat);
    n_tot++; if (rd !== 32'h0000_00F1) $display("FAIL lbu got %h want 000000f1", rd); else n_pass++;
    issue(1'b0, 2'd1, 1'b0, 32'hA, 32'h0, rd, er, lat);
    n_tot++; if (rd !== 32'hFFFF_8000) $display("FAIL lh got %h want ffff8000", rd); else n_pass++;
  endtask

  task automatic test_rmw();
    logic [31:0] rd, erd; logic er, eer; int lat, elat;
    ref_op(1'b1, 2'd2, 1'b0, 32'hC, 32'h1122_3344, erd, eer, elat);
    issue(1'b1, 2'd2, 1'b0, 32'hC, 32'h1122_3344, rd, er, lat);
    ref_op(1'b1, 2'd0, 1'b0, 32'hD, 32'h0000_00AB, erd, eer, elat);
    issue(1'b1, 2'd0, 1'b0, 32'hD, 32'hFFFF_FFAB, rd, er, lat);
    n_tot++; if (a_ren !== 1'b1 || a_wen !== 1'b0 || a_raddr !== 4'd3) $display("FAIL sb_accept got ren=%b wen=%b raddr=%0d want 1/0/3", a_ren, a_wen, a_raddr); else n_pass++;
    n_tot++; if (m_wen !== 1'b1 || m_waddr !== 4'd3 || m_wdata !== 32'h1122_AB44) $display("FAIL sb_write got wen=%b addr=%0d data=%h want 1/3/1122ab44", m_wen, m_waddr, m_wdata); else n_pass++;
    n_tot++; if (lat !== 2 || er !== 1'b0) $display("FAIL sb_latency got %0d want 2", lat); else n_pass++;
    ref_op(1'b1, 2'd1, 1'b0, 32'hE, 32'h0000_BEEF, erd, eer, elat);
    issue(1'b1, 2'd1, 1'b0, 32'hE, 32'h1234_BEEF, rd, er, lat);
    issue(1'b0, 2'd2, 1'b0, 32'hC, 32'h0, rd, er, lat);
    n_tot++; if (rd !== 32'hBEEF_AB44) $display("FAIL sh_result got %h want beefab44", rd); else n_pass++;
  endtask

  task automatic test_misalign();
    logic [31:0] rd, erd; logic er, eer; int lat, elat;
    ref_op(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, erd, eer, elat);
    issue(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    n_tot++; if (er !== 1'b1 || rd !== 32'd0 || a_ren !== 1'b0 || a_wen !== 1'b0) $display("FAIL lw_misalign got err=%b rd=%h ren=%b want 1/0/0", er, rd, a_ren); else n_pass++;
`else
    n_tot++; if (er !== 1'b0 || rd !== ref_mem[1]) $display("FAIL lw_misalign got err=%b rd=%h want 0/%h", er, rd, ref_mem[1]); else n_pass++;
`endif
    n_tot++; if (lat !== 1) $display("FAIL misalign_latency got %0d want 1", lat); else n_pass++;
  endtask

  task automatic test_alias();
    logic [31:0] rd, erd; logic er, eer; int lat, elat;
    ref_op(1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678, erd, eer, elat);
    issue(1'b1, 2'd2, 1'b0, 32'h0, 32'h1234_5678, rd, er, lat);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er, lat);
    n_tot++; if (rd !== 32'h1234_5678 || a_raddr !== 4'd0) $display("FAIL alias got %h raddr %0d want 12345678 raddr 0", rd, a_raddr); else n_pass++;
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] old;
    int seen;
    old = tmem[3];
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd0; i_req_addr = 32'hC; i_req_wdata = 32'h5A;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    i_rstn = 1'b0;
    @(negedge i_clk);
    n_tot++; if (o_mem_wen !== 1'b0) $display("FAIL midrst_wen got %b want 0", o_mem_wen); else n_pass++;
    seen = 0;
    @(posedge i_clk); #1;
    i_rstn = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      if (o_rsp_valid) seen++;
    end
    @(posedge i_clk); #1;
    n_tot++; if (seen != 0) $display("FAIL midrst_rsp got %0d pulses want 0", seen); else n_pass++;
    n_tot++; if (tmem[3] !== old) $display("FAIL midrst_mem got %h want %h", tmem[3], old); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd; logic er, eer, we, uns; logic [1:0] sz; int lat, elat, bad;
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
      addr = $urandom; wd = $urandom;
      ref_op(we, sz, uns, addr, wd, erd, eer, elat);
      issue(we, sz, uns, addr, wd, rd, er, lat);
      n_tot++;
      if (rd !== erd || er !== eer || lat !== elat || a_ready !== 1'b1) begin
        $display("FAIL rand_%0d we=%b sz=%0d u=%b a=%h got rd=%h err=%b lat=%0d want rd=%h err=%b lat=%0d",
                 k, we, sz, uns, addr, rd, er, lat, erd, eer, elat);
        bad++;
      end else n_pass++;
    end
    for (int i = 0; i < 16; i++) begin
      n_tot++; if (tmem[i] !== ref_mem[i]) $display("FAIL mem_word_%0d got %h want %h", i, tmem[i], ref_mem[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd; logic er, eer; int lat, elat;
    for (int k = 0; k < 8; k++) begin
      ref_op(1'b0, 2'd2, 1'b0, 32'(k * 4), 32'h0, erd, eer, elat);
      issue(1'b0, 2'd2, 1'b0, 32'(k * 4), 32'h0, rd, er, lat);
      n_tot++; if (a_ready !== 1'b1 || rd !== erd || lat !== 1) $display("FAIL b2b_%0d got ready=%b rd=%h want 1/%h", k, a_ready, rd, erd); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tmem[i] = $urandom;
      ref_mem[i] = tmem[i];
    end
    test_reset();
    test_word_and_loads();
    test_rmw();
    test_misalign();
    test_alias();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    n_tot++; if (n_both != 0) $display("FAIL ren_wen_overlap got %0d want 0", n_both); else n_pass++;
    n_tot++; if (n_leak != 0) $display("FAIL rdata_idle_nonzero got %0d want 0", n_leak); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
